// File: rtl/bios_watchdog_if.sv
// BIOS watchdog register bus: write strobe and register contents in,
// status, flash select and platform reset request out.
interface bios_watchdog_if;
    logic       WriteBiosWD;
    logic [7:0] BiosRegister;
    logic [2:0] BiosStatus;
    logic       BiosSel;
    logic       RstReq;

    modport master (
        output WriteBiosWD,
        output BiosRegister,
        input  BiosStatus,
        input  BiosSel,
        input  RstReq
    );

    modport slave (
        input  WriteBiosWD,
        input  BiosRegister,
        output BiosStatus,
        output BiosSel,
        output RstReq
    );
endinterface

// File: rtl/bios_watchdog.sv
// BIOS boot watchdog: counts ms ticks while BIOS runs, swaps flash
// and requests a platform reset on expiry, halts after repeated failures.
module bios_watchdog #(
    parameter int          PRESCALE   = 33000,
    parameter logic [15:0] BASE_TICKS = 16'd1000,
    parameter int          RST_LEN    = 8,
    parameter int          MAX_FAIL   = 2
) (
    input  logic           LpcClock,
    input  logic           PciReset,
    bios_watchdog_if.slave bus
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int RW = (RST_LEN > 1) ? $clog2(RST_LEN) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [RW-1:0] RST_LAST = RW'(RST_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_EXPIRE,
        S_DONE,
        S_HALT
    } state_t;

    state_t        r_state;
    logic          r_wrd;
    logic [PW-1:0] r_pre;
    logic [15:0]   r_cnt;
    logic [1:0]    r_sel;
    logic [1:0]    r_fail;
    logic          r_bsel;
    logic          r_to;
    logic          r_rst;
    logic [RW-1:0] r_rcnt;
    logic [2:0]    r_status;

    state_t        w_nstate;
    logic [PW-1:0] w_npre;
    logic [15:0]   w_ncnt;
    logic [1:0]    w_nsel;
    logic [1:0]    w_nfail;
    logic          w_nbsel;
    logic          w_nto;
    logic          w_nrst;
    logic [RW-1:0] w_nrcnt;

    logic          w_en;
    logic          w_done;
    logic          w_kick;
    logic [1:0]    w_tsel;
    logic          w_tick;
    logic [15:0]   w_load;

    // Register contents settle one cycle after the strobe, so decode on r_wrd.
    assign w_en   = bus.BiosRegister[7];
    assign w_done = bus.BiosRegister[6];
    assign w_tsel = bus.BiosRegister[5:4];
    assign w_kick = bus.BiosRegister[0];
    assign w_tick = (r_pre == PRE_LAST);
    assign w_load = BASE_TICKS << w_tsel;

    always_ff @(posedge LpcClock) begin
        if (PciReset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nstate;
        end
    end

    always_comb begin
        w_nstate = r_state;
        w_npre   = r_pre;
        w_ncnt   = r_cnt;
        w_nsel   = r_sel;
        w_nfail  = r_fail;
        w_nbsel  = r_bsel;
        w_nto    = r_to;
        w_nrst   = 1'b0;
        w_nrcnt  = r_rcnt;
        unique case (r_state)
            S_IDLE: begin
                w_npre = '0;
                w_ncnt = '0;
                if (r_wrd) begin
                    if (w_done) begin
                        w_nstate = S_DONE;
                    end else if (w_en) begin
                        w_nstate = S_RUN;
                        w_ncnt   = w_load;
                        w_nsel   = w_tsel;
                    end
                end
            end
            S_RUN: begin
                if (r_cnt == 16'd0) begin
                    w_nstate = S_EXPIRE;
                end else if (w_tick) begin
                    w_npre = '0;
                    w_ncnt = r_cnt - 16'd1;
                    if (r_cnt == 16'd1) begin
                        w_nstate = S_EXPIRE;
                    end
                end else begin
                    w_npre = r_pre + PW'(1);
                end
                // A write overrides the countdown, so a kick on the last tick wins.
                if (r_wrd) begin
                    if (w_done) begin
                        w_nstate = S_DONE;
                        w_npre   = '0;
                        w_ncnt   = '0;
                    end else if (!w_en) begin
                        w_nstate = S_IDLE;
                        w_npre   = '0;
                        w_ncnt   = '0;
                    end else if (w_kick || (w_tsel != r_sel)) begin
                        w_nstate = S_RUN;
                        w_npre   = '0;
                        w_ncnt   = w_load;
                        w_nsel   = w_tsel;
                    end
                end
                if (w_nstate == S_EXPIRE) begin
                    w_nbsel = ~r_bsel;
                    w_nto   = 1'b1;
                    w_nfail = (r_fail == 2'b11) ? r_fail : r_fail + 2'd1;
                    w_nrst  = 1'b1;
                    w_nrcnt = '0;
                    w_npre  = '0;
                    w_ncnt  = '0;
                end
            end
            S_EXPIRE: begin
                if (r_rcnt == RST_LAST) begin
                    w_nstate = (32'(r_fail) >= MAX_FAIL) ? S_HALT : S_IDLE;
                end else begin
                    w_nrst  = 1'b1;
                    w_nrcnt = r_rcnt + RW'(1);
                end
            end
            S_DONE: begin
                w_nstate = S_DONE;
            end
            S_HALT: begin
                w_nstate = S_HALT;
            end
            default: begin
                w_nstate = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge LpcClock) begin
        if (PciReset) begin
            r_wrd    <= 1'b0;
            r_pre    <= '0;
            r_cnt    <= '0;
            r_sel    <= '0;
            r_fail   <= '0;
            r_bsel   <= 1'b0;
            r_to     <= 1'b0;
            r_rst    <= 1'b0;
            r_rcnt   <= '0;
            r_status <= 3'b000;
        end else begin
            r_wrd    <= bus.WriteBiosWD;
            r_pre    <= w_npre;
            r_cnt    <= w_ncnt;
            r_sel    <= w_nsel;
            r_fail   <= w_nfail;
            r_bsel   <= w_nbsel;
            r_to     <= w_nto;
            r_rst    <= w_nrst;
            r_rcnt   <= w_nrcnt;
            r_status <= {w_nstate == S_RUN, w_nto, w_nbsel};
        end
    end

    assign bus.BiosStatus = r_status;
    assign bus.BiosSel    = r_bsel;
    assign bus.RstReq     = r_rst;

endmodule
